ascon_fsm_ctrl: RTL and testbench
=================================

// Module: ascon_fsm_ctrl
// PURPOSE
//  Sequencing FSM for the ASCON-128 encryption datapath (permutation + XOR begin/end + cipher/tag regs).
//  Drives round index, state-register enable, input select and all XOR/capture enables
//  through Init (p12), Associated Data (p6/block), Plaintext (p6/block) and Finalisation (p12).
//  Datapath carries all data; the controller only sequences it and handshakes input blocks.
// PARAMETERS
//  NB_AD_BLOCKS  1  number of 64-bit associated-data blocks per message (>=1)
//  NB_PT_BLOCKS  3  number of 64-bit plaintext blocks per message (>=1; last one enters finalisation)
// PORTS
//  clock_i             in   1  single clock, rising edge
//  reset_i             in   1  asynchronous, active-high reset
//  start_i             in   1  start one message; sampled only in IDLE
//  data_valid_i        in   1  current AD/PT block present on datapath data input
//  data_ready_o        out  1  controller waiting for a block (WAIT_AD / WAIT_PT)
//  round_o             out  4  round index to permutation (0..11; p6 uses 6..11)
//  enable_o            out  1  state register update enable (one round per cycle)
//  sel_init_o          out  1  1: permutation takes fresh IV||K||N, 0: feedback state
//  en_xor_data_begin_o out  1  XOR data block into x0 before round
//  en_xor_key_begin_o  out  1  XOR key into x1,x2 before round (finalisation)
//  en_xor_key_end_o    out  1  XOR key into x3,x4 after round
//  en_xor_lsb_end_o    out  1  XOR domain-separation 1 into LSB of x4 after round
//  en_cipher_o         out  1  capture ciphertext register this cycle
//  cipher_valid_o      out  1  ciphertext register holds a new block (1-cycle pulse)
//  en_tag_o            out  1  capture tag register this cycle
//  tag_valid_o         out  1  tag valid (1-cycle pulse, with done_o)
//  busy_o              out  1  1 in every state except IDLE
//  done_o              out  1  message complete (1-cycle pulse)
// BEHAVIOUR
//  - Reset: state IDLE, round/block counters 0, every output 0; takes effect immediately, also mid-message.
//  - States: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, END. 4-bit round counter, block counter ceil(log2) wide.
//  - Accept cycles are Mealy: the cycle a start/block is accepted is itself the first round.
//  - IDLE: start_i=1 -> round_o=0, enable_o=1, sel_init_o=1; -> INIT with counter=1. data_valid_i ignored.
//  - INIT: rounds 1..11, enable_o=1; round 11 asserts en_xor_key_end_o; -> WAIT_AD.
//  - WAIT_AD: data_ready_o=1, round_o=6. valid=0: enable_o=0, hold. valid=1: enable_o=1,
//    en_xor_data_begin_o=1, -> AD at round 7.
//  - AD: rounds 7..11; at 11 block count++; last AD block also asserts en_xor_lsb_end_o -> WAIT_PT, else -> WAIT_AD.
//  - WAIT_PT, block not last: round_o=6; on valid: enable_o, en_xor_data_begin_o, en_cipher_o -> PT round 7.
//  - WAIT_PT, last block: round_o=0; on valid: enable_o, en_xor_data_begin_o, en_xor_key_begin_o,
//    en_cipher_o -> FINAL round 1.
//  - PT: rounds 7..11, count++ at 11 -> WAIT_PT. FINAL: rounds 1..11; round 11 asserts en_xor_key_end_o, en_tag_o -> END.
//  - END: tag_valid_o=1, done_o=1 for one cycle, counters cleared -> IDLE.
//  - cipher_valid_o = en_cipher_o registered (one cycle later). Round counter never exceeds 11; wraps by state change.
//  - start_i outside IDLE ignored; data_valid_i ignored while data_ready_o=0. Block counters reset per message.
//  - All enable/select outputs 0 in IDLE, END and in WAIT states while data_valid_i=0.
// TESTING (cycle 0 = start accept, defaults, data_valid_i held 1)
//  1. Full message -> round_o 0..11,6..11 x3,0..11; cipher_valid_o at 19,25,31; tag_valid_o+done_o at 42 only.
//  2. Same run -> en_xor_key_end_o at 11 and 41; en_xor_lsb_end_o at 17; en_xor_key_begin_o at 30; sel_init_o at 0 only.
//  3. Drop data_valid_i for 5 cycles in WAIT_PT (2nd block) -> data_ready_o=1, enable_o=0, round_o=6 held; tag at 47.
//  4. start_i pulsed at cycle 20 -> ignored, sequence unchanged; busy_o=1 cycles 0..42.
//  5. reset_i asserted at cycle 15 -> all outputs 0 same cycle, IDLE; restart reproduces scenario 1.
//  6. NB_AD_BLOCKS=2, NB_PT_BLOCKS=1 -> lsb_end at 23, cipher capture at 24, key_end at 35, tag_valid_o at 36.

Source files
------------

// File: rtl/ascon_fsm_ctrl.sv
// ASCON-128 encryption sequencing FSM: round index, state enable, XOR/capture
// enables and AD/PT block handshake for Init, AD, PT and Finalisation phases.
//
// Ports:
//   clock_i, reset_i (async, active-high)
//   start_i           : start one message (IDLE only)
//   data_valid_i      : AD/PT block present on datapath input
//   data_ready_o      : waiting for a block
//   round_o           : round index to the permutation
//   enable_o          : state register update enable
//   sel_init_o        : permutation input = IV||K||N
//   en_xor_*_o        : XOR enables around the round
//   en_cipher_o       : capture ciphertext
//   cipher_valid_o    : ciphertext register fresh (pulse)
//   en_tag_o          : capture tag
//   tag_valid_o       : tag valid (pulse)
//   busy_o, done_o    : message in flight / complete
module ascon_fsm_ctrl #(
  parameter int NB_AD_BLOCKS = 1,
  parameter int NB_PT_BLOCKS = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       enable_o,
  output logic       sel_init_o,
  output logic       en_xor_data_begin_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_end_o,
  output logic       en_cipher_o,
  output logic       cipher_valid_o,
  output logic       en_tag_o,
  output logic       tag_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int NB_MAX =
    (NB_AD_BLOCKS > NB_PT_BLOCKS) ? NB_AD_BLOCKS : NB_PT_BLOCKS;
  localparam int BW = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;

  localparam logic [BW-1:0] LAST_AD = BW'(NB_AD_BLOCKS - 1);
  localparam logic [BW-1:0] LAST_PT = BW'(NB_PT_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_AD,
    S_AD,
    S_WAIT_PT,
    S_PT,
    S_FINAL,
    S_END
  } state_t;

  state_t        state_q, state_nx;
  logic [3:0]    rnd_q, rnd_nx;
  logic [BW-1:0] blk_q, blk_nx;
  logic          cv_q;
  logic          last_rnd;
  logic          last_ad;
  logic          last_pt;

  assign last_rnd = (rnd_q == 4'd11);
  assign last_ad  = (blk_q == LAST_AD);
  assign last_pt  = (blk_q == LAST_PT);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      blk_q   <= '0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_nx;
      rnd_q   <= rnd_nx;
      blk_q   <= blk_nx;
      cv_q    <= en_cipher_o;
    end
  end

  assign cipher_valid_o = cv_q;

  always_comb begin
    state_nx            = state_q;
    rnd_nx              = rnd_q;
    blk_nx              = blk_q;
    data_ready_o        = 1'b0;
    round_o             = 4'd0;
    enable_o            = 1'b0;
    sel_init_o          = 1'b0;
    en_xor_data_begin_o = 1'b0;
    en_xor_key_begin_o  = 1'b0;
    en_xor_key_end_o    = 1'b0;
    en_xor_lsb_end_o    = 1'b0;
    en_cipher_o         = 1'b0;
    en_tag_o            = 1'b0;
    tag_valid_o         = 1'b0;
    done_o              = 1'b0;
    busy_o              = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        // Accept cycle is already round 0 of the init permutation.
        if (start_i && !reset_i) begin
          busy_o     = 1'b1;
          enable_o   = 1'b1;
          sel_init_o = 1'b1;
          rnd_nx     = 4'd1;
          blk_nx     = '0;
          state_nx   = S_INIT;
        end
      end
      S_INIT: begin
        round_o  = rnd_q;
        enable_o = 1'b1;
        if (last_rnd) begin
          en_xor_key_end_o = 1'b1;
          rnd_nx           = 4'd0;
          state_nx         = S_WAIT_AD;
        end else begin
          rnd_nx = rnd_q + 4'd1;
        end
      end
      S_WAIT_AD: begin
        data_ready_o = 1'b1;
        round_o      = 4'd6;
        if (data_valid_i) begin
          enable_o            = 1'b1;
          en_xor_data_begin_o = 1'b1;
          rnd_nx              = 4'd7;
          state_nx            = S_AD;
        end
      end
      S_AD: begin
        round_o  = rnd_q;
        enable_o = 1'b1;
        if (last_rnd) begin
          rnd_nx = 4'd0;
          if (last_ad) begin
            en_xor_lsb_end_o = 1'b1;
            blk_nx           = '0;
            state_nx         = S_WAIT_PT;
          end else begin
            blk_nx   = blk_q + 1'b1;
            state_nx = S_WAIT_AD;
          end
        end else begin
          rnd_nx = rnd_q + 4'd1;
        end
      end
      S_WAIT_PT: begin
        data_ready_o = 1'b1;
        // Last PT block is absorbed by the first p12 round of finalisation.
        round_o      = last_pt ? 4'd0 : 4'd6;
        if (data_valid_i) begin
          enable_o            = 1'b1;
          en_xor_data_begin_o = 1'b1;
          en_cipher_o         = 1'b1;
          if (last_pt) begin
            en_xor_key_begin_o = 1'b1;
            rnd_nx             = 4'd1;
            state_nx           = S_FINAL;
          end else begin
            rnd_nx   = 4'd7;
            state_nx = S_PT;
          end
        end
      end
      S_PT: begin
        round_o  = rnd_q;
        enable_o = 1'b1;
        if (last_rnd) begin
          rnd_nx   = 4'd0;
          blk_nx   = blk_q + 1'b1;
          state_nx = S_WAIT_PT;
        end else begin
          rnd_nx = rnd_q + 4'd1;
        end
      end
      S_FINAL: begin
        round_o  = rnd_q;
        enable_o = 1'b1;
        if (last_rnd) begin
          en_xor_key_end_o = 1'b1;
          en_tag_o         = 1'b1;
          rnd_nx           = 4'd0;
          state_nx         = S_END;
        end else begin
          rnd_nx = rnd_q + 4'd1;
        end
      end
      S_END: begin
        tag_valid_o = 1'b1;
        done_o      = 1'b1;
        rnd_nx      = 4'd0;
        blk_nx      = '0;
        state_nx    = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// Scoreboard bench for ascon_fsm_ctrl: expected per-cycle output vectors are
// queued from hand-laid phase timelines; monitors pop while the DUT is busy.
module tb_ascon_fsm_ctrl;

  typedef struct packed {
    logic [3:0] rnd;
    logic en;
    logic sel;
    logic xdb;
    logic xkb;
    logic xke;
    logic xle;
    logic ec;
    logic cv;
    logic et;
    logic tv;
    logic busy;
    logic done;
    logic rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start1, dv1, start2, dv2;

  logic       rdy1, en1, sel1, xdb1, xkb1, xke1, xle1;
  logic       ec1, cv1, et1, tv1, busy1, done1;
  logic [3:0] rnd1;
  logic       rdy2, en2, sel2, xdb2, xkb2, xke2, xle2;
  logic       ec2, cv2, et2, tv2, busy2, done2;
  logic [3:0] rnd2;

  int checks = 0;
  int failures = 0;

  vec_t tr[$];
  vec_t q1[$];
  vec_t q2[$];
  int   exp_done1, exp_done2;
  int   cyc1 = 0, cyc2 = 0;
  bit   cvn;
  vec_t a1, e1, a2, e2;

  always #5 clk = ~clk;

  ascon_fsm_ctrl dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start1),
    .data_valid_i(dv1), .data_ready_o(rdy1), .round_o(rnd1),
    .enable_o(en1), .sel_init_o(sel1),
    .en_xor_data_begin_o(xdb1), .en_xor_key_begin_o(xkb1),
    .en_xor_key_end_o(xke1), .en_xor_lsb_end_o(xle1),
    .en_cipher_o(ec1), .cipher_valid_o(cv1), .en_tag_o(et1),
    .tag_valid_o(tv1), .busy_o(busy1), .done_o(done1)
  );

  ascon_fsm_ctrl #(.NB_AD_BLOCKS(2), .NB_PT_BLOCKS(1)) dut2 (
    .clock_i(clk), .reset_i(rst), .start_i(start2),
    .data_valid_i(dv2), .data_ready_o(rdy2), .round_o(rnd2),
    .enable_o(en2), .sel_init_o(sel2),
    .en_xor_data_begin_o(xdb2), .en_xor_key_begin_o(xkb2),
    .en_xor_key_end_o(xke2), .en_xor_lsb_end_o(xle2),
    .en_cipher_o(ec2), .cipher_valid_o(cv2), .en_tag_o(et2),
    .tag_valid_o(tv2), .busy_o(busy2), .done_o(done2)
  );

  function automatic vec_t pk1();
    vec_t v;
    v = {rnd1, en1, sel1, xdb1, xkb1, xke1, xle1, ec1, cv1,
         et1, tv1, busy1, done1, rdy1};
    return v;
  endfunction

  function automatic vec_t pk2();
    vec_t v;
    v = {rnd2, en2, sel2, xdb2, xkb2, xke2, xle2, ec2, cv2,
         et2, tv2, busy2, done2, rdy2};
    return v;
  endfunction

  task automatic chk(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t bs(input int r);
    vec_t v;
    v = '0;
    v.rnd = 4'(r);
    v.busy = 1'b1;
    return v;
  endfunction

  task automatic put(input vec_t v);
    v.cv = cvn;
    cvn = 1'b0;
    tr.push_back(v);
  endtask

  // Expected timeline: p12 init, per-AD wait+p6, per-PT wait(+stall)+p6,
  // last PT absorbed into p12 finalisation, then END.
  task automatic gen(input int nad, input int npt,
                     input int sblk, input int slen);
    vec_t e;
    tr.delete();
    cvn = 1'b0;
    e = bs(0); e.en = 1; e.sel = 1; put(e);
    for (int r = 1; r <= 11; r++) begin
      e = bs(r); e.en = 1; e.xke = (r == 11); put(e);
    end
    for (int b = 0; b < nad; b++) begin
      e = bs(6); e.rdy = 1; e.en = 1; e.xdb = 1; put(e);
      for (int r = 7; r <= 11; r++) begin
        e = bs(r); e.en = 1;
        e.xle = (r == 11) && (b == nad - 1);
        put(e);
      end
    end
    for (int b = 0; b < npt; b++) begin
      bit last;
      last = (b == npt - 1);
      if (b == sblk)
        for (int k = 0; k < slen; k++) begin
          e = bs(last ? 0 : 6); e.rdy = 1; put(e);
        end
      e = bs(last ? 0 : 6);
      e.rdy = 1; e.en = 1; e.xdb = 1; e.ec = 1; e.xkb = last;
      put(e);
      cvn = 1'b1;
      if (!last) begin
        for (int r = 7; r <= 11; r++) begin
          e = bs(r); e.en = 1; put(e);
        end
      end else begin
        for (int r = 1; r <= 11; r++) begin
          e = bs(r); e.en = 1;
          e.xke = (r == 11); e.et = (r == 11);
          put(e);
        end
      end
    end
    e = bs(0); e.tv = 1; e.done = 1; put(e);
  endtask

  always @(negedge clk) begin
    a1 = pk1();
    if (a1.busy) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected", a1, '0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_trace", a1, e1);
      end
      if (a1.done) chk_int("dut1_done_cycle", cyc1, exp_done1);
      cyc1++;
    end else begin
      chk("dut1_idle", a1, '0);
      cyc1 = 0;
    end
  end

  always @(negedge clk) begin
    a2 = pk2();
    if (a2.busy) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected", a2, '0);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_trace", a2, e2);
      end
      if (a2.done) chk_int("dut2_done_cycle", cyc2, exp_done2);
      cyc2++;
    end else begin
      chk("dut2_idle", a2, '0);
      cyc2 = 0;
    end
  end

  task automatic drain1(input string nm);
    for (int k = 0; k < 100 && q1.size() != 0; k++) @(posedge clk);
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL %s left=%0d required=0", nm, q1.size());
      q1.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  // stall cycles start at 24 (second PT block wait) in the default config
  task automatic run1(input string nm, input int slen,
                      input int pulse_at, input int rst_at);
    int n;
    gen(1, 3, 1, slen);
    n = (rst_at >= 0) ? rst_at : tr.size();
    for (int i = 0; i < n; i++) q1.push_back(tr[i]);
    exp_done1 = tr.size() - 1;
    for (int c = 0; c < tr.size() + 2; c++) begin
      @(posedge clk); #1;
      start1 = (c == 0) || (c == pulse_at);
      dv1 = !(c >= 24 && c < 24 + slen);
      if (c == rst_at) begin
        start1 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
    end
    start1 = 1'b0;
    dv1 = 1'b1;
    drain1(nm);
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0; dv1 = 1'b1;
    start2 = 1'b0; dv2 = 1'b1;
    exp_done1 = 42; exp_done2 = 36;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", pk1(), '0);
    start1 = 1'b1;
    #1;
    chk("reset_blocks_start", pk1(), '0);
    start1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run1("full_msg", 0, -1, -1);
    chk_int("full_msg_len", tr.size(), 43);
    run1("pt_stall", 5, -1, -1);
    chk_int("pt_stall_len", tr.size(), 48);
    run1("start_ignored", 0, 20, -1);
    run1("mid_reset", 0, -1, 15);
    run1("restart", 0, -1, -1);

    gen(2, 1, -1, 0);
    chk_int("cfg2_len", tr.size(), 37);
    foreach (tr[i]) q2.push_back(tr[i]);
    exp_done2 = tr.size() - 1;
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int k = 0; k < 100 && q2.size() != 0; k++) @(posedge clk);
    checks++;
    if (q2.size() != 0) begin
      failures++;
      $display("FAIL cfg2_drain left=%0d required=0", q2.size());
    end
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
